id_hazard_unit: RTL and testbench

- Decode-stage interlock. Sits directly upstream of the ID/EX pipeline register and produces the `id_shouldStall` that register consumes.
- Holds a shift-register scoreboard of in-flight register-file writes (EX, MEM, WB). The pipeline has no forwarding, so ID must stall until every producer of its source registers has retired.
- Also converts a taken jump/branch resolved in EX into a flush of the wrong-path instruction in ID.

---
 rtl/id_hazard_unit.sv | 155 +++++++++++++++
 tb/tb_id_hazard_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// id_hazard_unit
// Decode-stage interlock for a pipeline with no forwarding paths.
// It keeps a shift-register scoreboard of register-file writes that are still
// in flight. It stalls ID until every producer of the ID instruction's sources
// has retired. A taken jump/branch resolved in EX becomes a flush of the
// wrong-path instruction sitting in ID.
// Optional build macro: HAZARD_PERF_CNT_EN adds the stall-cycle and
// flush-event performance counters (hz_stallCycles, hz_flushCount).

module id_hazard_unit #(
    parameter int SB_DEPTH = 3,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic [ADDR_W-1:0] id_rsAddress,
    input  logic [ADDR_W-1:0] id_rtAddress,
    input  logic              id_usesRs,
    input  logic              id_usesRt,
    input  logic [ADDR_W-1:0] id_registerWriteAddress,
    input  logic              id_ifWriteRegsFile,
    input  logic              ex_shouldJumpOrBranch,
    output logic              id_shouldStall,
    output logic              id_shouldFlush,
    output logic              if_pcWriteEnable,
    output logic [7:0]        hz_stallLength
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       hz_stallCycles,
    output logic [31:0]       hz_flushCount
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hzState_t;

    // Scoreboard slot 0 is the instruction now in EX; slot SB_DEPTH-1 is the oldest.
    logic [SB_DEPTH-1:0] slotValid;
    logic [ADDR_W-1:0]   slotAddr [SB_DEPTH];

    hzState_t   state;
    logic [7:0] stallLen;

    logic rsMatch;
    logic rtMatch;
    logic rsHit;
    logic rtHit;
    logic newSlotValid;

    // Look for any valid in-flight producer of the rs or rt source register.
    always_comb begin
        rsMatch = 1'b0;
        rtMatch = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (slotValid[i] && (slotAddr[i] == id_rsAddress)) begin
                rsMatch = 1'b1;
            end
            if (slotValid[i] && (slotAddr[i] == id_rtAddress)) begin
                rtMatch = 1'b1;
            end
        end
    end

    // Register 0 is hardwired, so reading it can never depend on a producer.
    assign rsHit = id_usesRs && (id_rsAddress != '0) && rsMatch;
    assign rtHit = id_usesRt && (id_rtAddress != '0) && rtMatch;

    // A flush wins over a stall: the wrong-path instruction must not hold up fetch.
    assign id_shouldFlush   = ex_shouldJumpOrBranch;
    assign id_shouldStall   = (rsHit || rtHit) && !ex_shouldJumpOrBranch;
    assign if_pcWriteEnable = !id_shouldStall;

    // The entry for the ID instruction follows the bubble that ID/EX inserts on a stall or flush.
    assign newSlotValid = id_ifWriteRegsFile && (id_registerWriteAddress != '0)
                          && !id_shouldStall && !id_shouldFlush;

    // Advance the scoreboard one pipeline stage per enabled cycle; the oldest entry falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotValid <= '0;
            for (int k = 0; k < SB_DEPTH; k++) begin
                slotAddr[k] <= '0;
            end
        end else if (cpu_en) begin
            for (int k = 1; k < SB_DEPTH; k++) begin
                slotValid[k] <= slotValid[k-1];
                slotAddr[k]  <= slotAddr[k-1];
            end
            slotValid[0] <= newSlotValid;
            slotAddr[0]  <= id_registerWriteAddress;
        end
    end

    // Track stall runs and report their length. The length saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            stallLen <= 8'd0;
        end else if (cpu_en) begin
            case (state)
                RUN: begin
                    if (id_shouldStall) begin
                        state    <= STALL;
                        stallLen <= 8'd1;
                    end
                end
                STALL: begin
                    if (id_shouldFlush) begin
                        state    <= RUN;
                        stallLen <= 8'd0;
                    end else if (id_shouldStall) begin
                        state    <= STALL;
                        stallLen <= (stallLen == 8'hFF) ? stallLen : stallLen + 8'd1;
                    end else begin
                        state    <= RUN;
                        stallLen <= 8'd0;
                    end
                end
                default: begin
                    state    <= RUN;
                    stallLen <= 8'd0;
                end
            endcase
        end
    end

    assign hz_stallLength = stallLen;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycleCnt;
    logic [31:0] flushEventCnt;

    // Free-running performance counters. They count only enabled cycles and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycleCnt <= 32'd0;
            flushEventCnt <= 32'd0;
        end else if (cpu_en) begin
            if (id_shouldStall) begin
                stallCycleCnt <= stallCycleCnt + 32'd1;
            end
            if (id_shouldFlush) begin
                flushEventCnt <= flushEventCnt + 32'd1;
            end
        end
    end

    assign hz_stallCycles = stallCycleCnt;
    assign hz_flushCount  = flushEventCnt;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// tb_id_hazard_unit
// Directed scoreboard bench for id_hazard_unit.
// The driver issues one stimulus vector per cycle and queues the hand-computed
// expected outputs for that cycle. The monitor pops and compares them at the
// falling edge.
// Build with HAZARD_PERF_CNT_EN defined to also check the performance counters.

module tb_id_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       cpu_en;
    logic [4:0] id_rsAddress;
    logic [4:0] id_rtAddress;
    logic       id_usesRs;
    logic       id_usesRt;
    logic [4:0] id_registerWriteAddress;
    logic       id_ifWriteRegsFile;
    logic       ex_shouldJumpOrBranch;
    logic       id_shouldStall;
    logic       id_shouldFlush;
    logic       if_pcWriteEnable;
    logic [7:0] hz_stallLength;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] hz_stallCycles;
    logic [31:0] hz_flushCount;
`endif

    typedef struct {
        int         cyc;
        logic       stall;
        logic       flush;
        logic [7:0] len;
        string      name;
    } expect_t;

    expect_t expQ[$];
    int      cycleCount = 0;
    int      vecCount   = 0;
    int      missCount  = 0;

    id_hazard_unit #(
        .SB_DEPTH(3),
        .ADDR_W  (5)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cpu_en                 (cpu_en),
        .id_rsAddress           (id_rsAddress),
        .id_rtAddress           (id_rtAddress),
        .id_usesRs              (id_usesRs),
        .id_usesRt              (id_usesRt),
        .id_registerWriteAddress(id_registerWriteAddress),
        .id_ifWriteRegsFile     (id_ifWriteRegsFile),
        .ex_shouldJumpOrBranch  (ex_shouldJumpOrBranch),
        .id_shouldStall         (id_shouldStall),
        .id_shouldFlush         (id_shouldFlush),
        .if_pcWriteEnable       (if_pcWriteEnable),
        .hz_stallLength         (hz_stallLength)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .hz_stallCycles         (hz_stallCycles),
        .hz_flushCount          (hz_flushCount)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to tag queued expectations
    initial begin
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    // Drive one vector just after the rising edge and queue what must be seen this cycle
    task automatic applyStimulus(input logic en, input logic [4:0] rs, input logic uRs,
                                 input logic [4:0] rt, input logic uRt,
                                 input logic [4:0] wr, input logic wEn, input logic jmp,
                                 input logic expStall, input logic expFlush,
                                 input logic [7:0] expLen, input string name);
        expect_t e;
        @(posedge clk);
        #1;
        cpu_en                  = en;
        id_rsAddress            = rs;
        id_usesRs               = uRs;
        id_rtAddress            = rt;
        id_usesRt               = uRt;
        id_registerWriteAddress = wr;
        id_ifWriteRegsFile      = wEn;
        ex_shouldJumpOrBranch   = jmp;
        e.cyc   = cycleCount;
        e.stall = expStall;
        e.flush = expFlush;
        e.len   = expLen;
        e.name  = name;
        expQ.push_back(e);
    endtask

    task automatic idleCycle(input string name);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, name);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idleCycle("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Producer of r5, then a consumer of r5 that waits out all three slots
    task automatic runRsStall();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "rs_prod");
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, "rs_stall1");
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, "rs_stall2");
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, "rs_stall3");
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, "rs_release");
        idleCycle("rs_len_clear");
    endtask

    // Monitor: compare queued expectations at the falling edge of their cycle
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
                e = expQ.pop_front();
                vecCount++;
                if (e.cyc != cycleCount || id_shouldStall !== e.stall || id_shouldFlush !== e.flush ||
                    if_pcWriteEnable !== !e.stall || hz_stallLength !== e.len) begin
                    missCount++;
                    $display("[TB] FAIL %s cyc=%0d/%0d: got stall=%0b flush=%0b pcwe=%0b len=%0d, want stall=%0b flush=%0b pcwe=%0b len=%0d",
                             e.name, e.cyc, cycleCount, id_shouldStall, id_shouldFlush, if_pcWriteEnable,
                             hz_stallLength, e.stall, e.flush, !e.stall, e.len);
                end
            end
        end
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #200000;
        missCount++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Directed stimulus sequence
    initial begin
        rst_n                   = 1'b0;
        cpu_en                  = 1'b1;
        id_rsAddress            = '0;
        id_rtAddress            = '0;
        id_usesRs               = 1'b0;
        id_usesRt               = 1'b0;
        id_registerWriteAddress = '0;
        id_ifWriteRegsFile      = 1'b0;
        ex_shouldJumpOrBranch   = 1'b0;

        doReset();
        runRsStall();
        idleCycle("drain");
        idleCycle("drain");
        idleCycle("drain");

        // rt dependency; use flags low must not hazard
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "rt_prod");
        applyStimulus(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rt_unused");
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd12, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "rt_stall1");
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd12, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "rt_stall2");
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd12, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd2, "rt_release");
        idleCycle("rt_len_clear");

        // r0 exemption, self-dependency, then freeze with cpu_en low
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "r0_prod");
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "r0_read");
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "self_dep");
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "frz_stall1");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "frz_hold");
        end
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "frz_resume2");
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, "frz_resume3");
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, "frz_release");
        idleCycle("frz_len_clear");

        // Flush overrides stall and the flushed write to r9 is not tracked
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "fl_prod");
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "fl_override");
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "fl_r9_free");
        idleCycle("fl_drain");

        // Flush arriving during a stall run returns the FSM to RUN
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "fs_prod");
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "fs_stall1");
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "fs_stall2");
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd2, "fs_flush");
        idleCycle("fs_run");

        // Asynchronous reset between edges in the middle of a stall
        applyStimulus(1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "ar_prod");
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "ar_stall1");
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "ar_stall2");
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "ar_async");
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "ar_after1");
        applyStimulus(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "ar_after2");

        // Fresh run: one rs stall scenario followed by a single flush
        doReset();
        runRsStall();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "pc_flush");
        idleCycle("pc_idle");
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        #1;
        vecCount++;
        if (hz_stallCycles !== 32'd3 || hz_flushCount !== 32'd1) begin
            missCount++;
            $display("[TB] FAIL perf_counters: got stallCycles=%0d flushCount=%0d, want stallCycles=3 flushCount=1",
                     hz_stallCycles, hz_flushCount);
        end
`endif

        repeat (3) @(negedge clk);
        #1;
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL queue_drain: got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
